// File: rtl/mode_cycler.sv
// mode_cycler: per-channel press-to-advance mode counters with optional
// radio-button exclusivity and idle auto-off; all outputs registered.
module mode_cycler #(
  parameter int  CHANNELS        = 4,
  parameter int  MODES           = 2,
  parameter int  EXCLUSIVE       = 0,
  parameter int  AUTO_OFF_CYCLES = 0,
  localparam int MW              = $clog2(MODES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNELS-1:0]    in,
  input  logic [CHANNELS-1:0]    clr,
  output logic [CHANNELS*MW-1:0] mode,
  output logic [CHANNELS-1:0]    en,
  output logic [CHANNELS-1:0]    changed
);
  logic [CHANNELS-1:0] in_hist_q;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] press_nz;
  logic [CHANNELS-1:0] win_oh;
  logic [CHANNELS-1:0] kill;
  logic [CHANNELS-1:0] expire;
  logic [CHANNELS-1:0] en_q;
  logic [CHANNELS-1:0] changed_q;
  logic [MW-1:0]       mode_q [CHANNELS];
  logic [MW-1:0]       mode_d [CHANNELS];
  logic [MW-1:0]       inc    [CHANNELS];

  // History resets to all ones so a button held across reset release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_hist_q <= '1;
    else     in_hist_q <= in;
  end

  assign rise = in & ~in_hist_q;

  always_comb begin
    press_nz = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      inc[i]      = (mode_q[i] == MW'(MODES - 1)) ? '0 : mode_q[i] + MW'(1);
      press_nz[i] = rise[i] & ~clr[i] & (inc[i] != '0);
    end
  end

  // Lowest-index nonzero-landing press wins; a wrapping press kills nobody.
  assign win_oh = press_nz & (~press_nz + CHANNELS'(1));
  assign kill   = (EXCLUSIVE != 0 && |press_nz) ? ~win_oh : '0;

  if (AUTO_OFF_CYCLES > 0) begin : g_timer
    logic [31:0] idle_q [CHANNELS];
    logic [31:0] idle_d [CHANNELS];

    always_comb begin
      expire = '0;
      for (int i = 0; i < CHANNELS; i++) begin
        expire[i] = (mode_q[i] != '0) && (idle_q[i] == 32'(AUTO_OFF_CYCLES - 1));
        if (rise[i] || clr[i] || mode_q[i] == '0 || expire[i]) idle_d[i] = '0;
        else                                                  idle_d[i] = idle_q[i] + 32'd1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < CHANNELS; i++) idle_q[i] <= '0;
      end else begin
        for (int i = 0; i < CHANNELS; i++) idle_q[i] <= idle_d[i];
      end
    end
  end else begin : g_no_timer
    assign expire = '0;
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr[i])         mode_d[i] = '0;
      else if (kill[i])   mode_d[i] = '0;
      else if (rise[i])   mode_d[i] = inc[i];
      else if (expire[i]) mode_d[i] = '0;
      else                mode_d[i] = mode_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) mode_q[i] <= '0;
      en_q      <= '0;
      changed_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        mode_q[i]    <= mode_d[i];
        en_q[i]      <= (mode_d[i] != '0);
        changed_q[i] <= (mode_d[i] != mode_q[i]);
      end
    end
  end

  always_comb begin
    mode = '0;
    for (int i = 0; i < CHANNELS; i++) mode[i*MW +: MW] = mode_q[i];
  end

  assign en      = en_q;
  assign changed = changed_q;
endmodule

// File: tb/tb_mode_cycler.sv
// Bench for mode_cycler: four configurations driven side by side, a queue
// scoreboard fed by a cycle model, plus directed checks of the key scenarios.
module tb_mode_cycler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [0:0] a_in, a_clr, a_mode, a_en, a_chg;
  logic [3:0] b_in, b_clr, b_en, b_chg;
  logic [7:0] b_mode;
  logic [3:0] c_in, c_clr, c_mode, c_en, c_chg;
  logic [3:0] d_in, d_clr, d_en, d_chg;
  logic [7:0] d_mode;

  mode_cycler #(.CHANNELS(1), .MODES(2), .EXCLUSIVE(0), .AUTO_OFF_CYCLES(0)) u_a (
    .clk(clk), .rst(rst), .in(a_in), .clr(a_clr), .mode(a_mode), .en(a_en), .changed(a_chg));
  mode_cycler #(.CHANNELS(4), .MODES(3), .EXCLUSIVE(0), .AUTO_OFF_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .in(b_in), .clr(b_clr), .mode(b_mode), .en(b_en), .changed(b_chg));
  mode_cycler #(.CHANNELS(4), .MODES(2), .EXCLUSIVE(1), .AUTO_OFF_CYCLES(0)) u_c (
    .clk(clk), .rst(rst), .in(c_in), .clr(c_clr), .mode(c_mode), .en(c_en), .changed(c_chg));
  mode_cycler #(.CHANNELS(4), .MODES(3), .EXCLUSIVE(0), .AUTO_OFF_CYCLES(10)) u_d (
    .clk(clk), .rst(rst), .in(d_in), .clr(d_clr), .mode(d_mode), .en(d_en), .changed(d_chg));

  localparam int CH_P[4] = '{1, 4, 4, 4};
  localparam int MD_P[4] = '{2, 3, 2, 3};
  localparam int EX_P[4] = '{0, 0, 1, 0};
  localparam int AO_P[4] = '{0, 0, 0, 10};
  localparam int MW_P[4] = '{1, 2, 1, 2};

  typedef struct {
    int         inst;
    logic [7:0] mode;
    logic [3:0] en;
    logic [3:0] chg;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_n   = 0;
  int   md  [4][4];
  bit   hist[4][4];
  int   age [4][4];
  bit   chg [4][4];
  int   t2_exp[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] in_of(input int n);
    case (n)
      0:       return {3'b000, a_in};
      1:       return b_in;
      2:       return c_in;
      default: return d_in;
    endcase
  endfunction

  function automatic logic [3:0] clr_of(input int n);
    case (n)
      0:       return {3'b000, a_clr};
      1:       return b_clr;
      2:       return c_clr;
      default: return d_clr;
    endcase
  endfunction

  function automatic logic [7:0] act_mode(input int n);
    case (n)
      0:       return {7'b0, a_mode};
      1:       return b_mode;
      2:       return {4'b0, c_mode};
      default: return d_mode;
    endcase
  endfunction

  function automatic logic [3:0] act_en(input int n);
    case (n)
      0:       return {3'b000, a_en};
      1:       return b_en;
      2:       return c_en;
      default: return d_en;
    endcase
  endfunction

  function automatic logic [3:0] act_chg(input int n);
    case (n)
      0:       return {3'b000, a_chg};
      1:       return b_chg;
      2:       return c_chg;
      default: return d_chg;
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 4; n++)
      for (int c = 0; c < 4; c++) begin
        md[n][c] = 0; hist[n][c] = 1'b1; age[n][c] = 0; chg[n][c] = 1'b0;
      end
  endtask

  // Cycle model: one clock edge of instance n with the inputs currently driven.
  task automatic model_step(input int n);
    logic [3:0] vi, vc;
    bit r[4];
    int win, nm, nxt;
    bit expire;
    vi  = in_of(n);
    vc  = clr_of(n);
    win = -1;
    for (int c = 0; c < 4; c++) r[c] = 1'b0;
    for (int c = 0; c < CH_P[n]; c++) begin
      r[c] = vi[c] && !hist[n][c];
      if (win < 0 && r[c] && !vc[c] && ((md[n][c] + 1) % MD_P[n]) != 0) win = c;
    end
    for (int c = 0; c < CH_P[n]; c++) begin
      nxt    = (md[n][c] + 1) % MD_P[n];
      expire = AO_P[n] > 0 && md[n][c] != 0 && age[n][c] == AO_P[n] - 1;
      if (vc[c])                                   nm = 0;
      else if (EX_P[n] != 0 && win >= 0 && c != win) nm = 0;
      else if (r[c])                               nm = nxt;
      else if (expire)                             nm = 0;
      else                                         nm = md[n][c];
      chg[n][c]  = (nm != md[n][c]);
      age[n][c]  = (r[c] || vc[c] || md[n][c] == 0 || expire) ? 0 : age[n][c] + 1;
      md[n][c]   = nm;
      hist[n][c] = vi[c];
    end
  endtask

  function automatic exp_t exp_of(input int n);
    exp_t e;
    e.inst = n; e.mode = '0; e.en = '0; e.chg = '0;
    for (int c = 0; c < CH_P[n]; c++) begin
      e.mode   = e.mode | (8'(md[n][c]) << (c * MW_P[n]));
      e.en[c]  = (md[n][c] != 0);
      e.chg[c] = chg[n][c];
    end
    return e;
  endfunction

  task automatic drain(input string tag);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s%0d_i%0d_mode", tag, cyc_n, e.inst), 32'(act_mode(e.inst)), 32'(e.mode));
      check($sformatf("%s%0d_i%0d_en", tag, cyc_n, e.inst), 32'(act_en(e.inst)), 32'(e.en));
      check($sformatf("%s%0d_i%0d_chg", tag, cyc_n, e.inst), 32'(act_chg(e.inst)), 32'(e.chg));
    end
  endtask

  task automatic cyc();
    for (int n = 0; n < 4; n++) begin
      model_step(n);
      exp_q.push_back(exp_of(n));
    end
    @(posedge clk);
    #1;
    cyc_n++;
    drain("sb_c");
  endtask

  // Reset is raised away from the edge so the zeroed outputs prove it acts asynchronously.
  task automatic reset_for(input int ncyc);
    rst = 1'b1;
    model_reset();
    #1;
    for (int n = 0; n < 4; n++) exp_q.push_back(exp_of(n));
    drain("rst_async_c");
    repeat (ncyc) @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) exp_q.push_back(exp_of(n));
    drain("rst_hold_c");
    rst = 1'b0;
  endtask

  task automatic all_in(input logic v);
    a_in = v; b_in = {4{v}}; c_in = {4{v}}; d_in = {4{v}};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    t2_exp = '{1, 2, 0, 1};
    a_clr = '0; b_clr = '0; c_clr = '0; d_clr = '0;
    all_in(1'b1);
    reset_for(2);
    repeat (3) cyc();
    check("t6_held_at_release_d_en", 32'(d_en), 32'h0);
    all_in(1'b0);
    cyc();

    // T1: two 3-cycle presses on the single-channel toggle
    a_in = 1'b1; cyc();
    check("t1_on_en", 32'(a_en), 32'd1);
    check("t1_on_chg", 32'(a_chg), 32'd1);
    repeat (2) begin
      cyc();
      check("t1_held_chg", 32'(a_chg), 32'd0);
      check("t1_held_en", 32'(a_en), 32'd1);
    end
    a_in = 1'b0; repeat (3) cyc();
    a_in = 1'b1; cyc();
    check("t1_off_en", 32'(a_en), 32'd0);
    check("t1_off_chg", 32'(a_chg), 32'd1);
    repeat (2) cyc();
    check("t1_off_held_chg", 32'(a_chg), 32'd0);
    a_in = 1'b0; repeat (2) cyc();

    // T2: four presses on a 3-mode channel
    for (int k = 0; k < 4; k++) begin
      b_in = 4'b0001; cyc();
      check($sformatf("t2_mode0_p%0d", k), 32'(b_mode[1:0]), 32'(t2_exp[k]));
      check($sformatf("t2_en0_p%0d", k), 32'(b_en[0]), 32'(t2_exp[k] != 0));
      b_in = 4'b0000; cyc();
    end

    // T3: exclusivity, simultaneous presses, wrapping press
    c_in = 4'b0100; cyc();
    check("t3_ch2_on", 32'(c_mode), 32'h4);
    c_in = 4'b0000; cyc();
    c_in = 4'b1001; cyc();
    check("t3_excl_mode", 32'(c_mode), 32'h1);
    check("t3_excl_chg", 32'(c_chg), 32'h5);
    c_in = 4'b0000; cyc();
    c_in = 4'b0101; cyc();
    check("t3_wrap_mode", 32'(c_mode), 32'h4);
    check("t3_wrap_chg", 32'(c_chg), 32'h5);
    c_in = 4'b0000; cyc();

    // T4: auto-off after 10 idle cycles, and a repress at cycle 9
    d_in = 4'b0010; cyc();
    check("t4_press_en1", 32'(d_en[1]), 32'd1);
    d_in = 4'b0000;
    for (int j = 1; j <= 10; j++) begin
      cyc();
      check($sformatf("t4_en1_j%0d", j), 32'(d_en[1]), 32'(j < 10));
    end
    check("t4_expire_chg1", 32'(d_chg[1]), 32'd1);
    d_in = 4'b0010; cyc();
    d_in = 4'b0000;
    repeat (8) cyc();
    d_in = 4'b0010; cyc();
    check("t4_repress_mode1", 32'(d_mode[3:2]), 32'd2);
    d_in = 4'b0000;
    for (int j = 1; j <= 10; j++) begin
      cyc();
      check($sformatf("t4_re_en1_j%0d", j), 32'(d_en[1]), 32'(j < 10));
    end

    // T5: rise and clr together at mode 1; clr at mode 0
    a_in = 1'b1; cyc();
    check("t5_setup_mode", 32'(a_mode), 32'd1);
    a_in = 1'b0; cyc();
    a_in = 1'b1; a_clr = 1'b1; cyc();
    check("t5_clr_mode", 32'(a_mode), 32'd0);
    check("t5_clr_chg", 32'(a_chg), 32'd1);
    a_in = 1'b0; cyc();
    check("t5_clr_at0_chg", 32'(a_chg), 32'd0);
    a_clr = 1'b0; cyc();

    // T6: reset mid-timeout with buttons held through reset
    d_in = 4'b0001; cyc();
    check("t6_setup_en0", 32'(d_en[0]), 32'd1);
    a_in = 1'b1; b_in = 4'b0001; c_in = 4'b0001;
    repeat (4) cyc();
    reset_for(2);
    repeat (12) cyc();
    check("t6_no_press_d_mode", 32'(d_mode), 32'h0);
    check("t6_no_press_a_en", 32'(a_en), 32'd0);
    all_in(1'b0); cyc();

    // Random traffic: dense, then sparse enough for timeouts to fire
    for (int k = 0; k < 300; k++) begin
      a_in = 1'($urandom); b_in = 4'($urandom); c_in = 4'($urandom); d_in = 4'($urandom);
      a_clr = 1'($urandom & $urandom & $urandom);
      b_clr = 4'($urandom & $urandom & $urandom);
      c_clr = 4'($urandom & $urandom & $urandom);
      d_clr = 4'($urandom & $urandom & $urandom);
      if (k == 150) reset_for(1);
      cyc();
    end
    for (int k = 0; k < 400; k++) begin
      a_in = 1'($urandom & $urandom & $urandom);
      b_in = 4'($urandom & $urandom & $urandom & $urandom);
      c_in = 4'($urandom & $urandom & $urandom & $urandom);
      d_in = 4'($urandom & $urandom & $urandom & $urandom);
      a_clr = 1'($urandom & $urandom & $urandom & $urandom & $urandom);
      b_clr = 4'($urandom & $urandom & $urandom & $urandom & $urandom);
      c_clr = 4'($urandom & $urandom & $urandom & $urandom & $urandom);
      d_clr = 4'($urandom & $urandom & $urandom & $urandom & $urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
